// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: memory-mapped peripheral bus between the pipeline and gpio_ctrl.
// Handshake: sel marks a single-cycle access with no wait state; when sel=1,
// we selects write (wdata applied at that edge) or read (rdata valid one cycle later).
interface gpio_ctrl_if;
    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO with direction control, input synchroniser,
// sticky rise/fall status (write-1-to-clear) and a level interrupt.
// Optional feature macro: GPIO_CTRL_SETCLR_EN enables the OUT_SET/OUT_CLR
// aliases at register indices 6 and 7; without it those addresses are inert.
module gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_ctrl_if.slave        bus,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    localparam logic [2:0] A_OUT     = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_RISE_EN = 3'd3;
    localparam logic [2:0] A_FALL_EN = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;
`ifdef GPIO_CTRL_SETCLR_EN
    localparam logic [2:0] A_OUT_SET = 3'd6;
    localparam logic [2:0] A_OUT_CLR = 3'd7;
`endif

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [31:0]      r_rdata;

    logic             w_wr;
    logic             w_rd;
    logic [2:0]       w_idx;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_out_next;
    logic [31:0]      w_rd_mux;
    logic             w_unused_bits;

    assign w_wr    = bus.sel & bus.we;
    assign w_rd    = bus.sel & ~bus.we;
    assign w_idx   = bus.addr[4:2];
    assign w_wdata = bus.wdata[WIDTH-1:0];
    // Byte-offset bits and data above WIDTH carry no meaning here.
    assign w_unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Edge detection compares the synchronised level against its one-cycle history.
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_sync & ~r_prev;
    assign w_fall  = ~w_sync & r_prev;
    assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr   = (w_wr && (w_idx == A_STATUS)) ? w_wdata : '0;

    // Next OUT value from plain writes and, when enabled, the set/clear aliases.
    always_comb begin
        w_out_next = r_out;
        if (w_wr) begin
            case (w_idx)
                A_OUT:     w_out_next = w_wdata;
`ifdef GPIO_CTRL_SETCLR_EN
                A_OUT_SET: w_out_next = r_out | w_wdata;
                A_OUT_CLR: w_out_next = r_out & ~w_wdata;
`endif
                default:   w_out_next = r_out;
            endcase
        end
    end

    // Read mux: zero-extends every register; IN shows the synchronised pin level.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_idx)
            A_OUT:     w_rd_mux = 32'(r_out);
            A_DIR:     w_rd_mux = 32'(r_dir);
            A_IN:      w_rd_mux = 32'(w_sync);
            A_RISE_EN: w_rd_mux = 32'(r_rise_en);
            A_FALL_EN: w_rd_mux = 32'(r_fall_en);
            A_STATUS:  w_rd_mux = 32'(r_status);
            default:   w_rd_mux = 32'd0;
        endcase
    end

    // Control registers; a new edge event wins over a simultaneous W1C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
        end else begin
            r_out    <= w_out_next;
            r_status <= w_event | (r_status & ~w_clr);
            if (w_wr && (w_idx == A_DIR))     r_dir     <= w_wdata;
            if (w_wr && (w_idx == A_RISE_EN)) r_rise_en <= w_wdata;
            if (w_wr && (w_idx == A_FALL_EN)) r_fall_en <= w_wdata;
        end
    end

    // Input synchroniser chain followed by the history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync;
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign bus.rdata = r_rdata;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_dir;
    assign irq       = |r_status;

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised, register-mapped GPIO controller; next generation of the single-register pass-through GPIO. It provides per-bit direction control, a multi-stage input synchroniser, per-bit rising/falling edge detection with sticky write-1-to-clear status, and a single level interrupt. It sits on the pipeline's memory-mapped peripheral bus beside the other MMIO slaves.

## Interface
- WIDTH, 32: number of GPIO pins, legal range 1..32.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- sel  in  1  bus access strobe, one cycle per access.
- we  in  1  1 = write, 0 = read; qualified by sel.
- addr  in  5  byte address; addr[4:2] selects the register, addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  pin output values (OUT register).
- gpio_oe  out  WIDTH  pin output enables (DIR register, 1 = drive).
- irq  out  1  level interrupt, OR of STATUS bits.

## Operation
- Register map by addr[4:2]:
  - 0 OUT: rw.
  - 1 DIR: rw.
  - 2 IN: ro, synchronised pin value.
  - 3 RISE_EN: rw.
  - 4 FALL_EN: rw.
  - 5 STATUS: read; write-1-to-clear.
  - 6 OUT_SET, 7 OUT_CLR: see Configuration.
- Bits [31:WIDTH]: ignored on write, read as 0.
- Writes to IN are ignored.
- Synchroniser:
  - SYNC_STAGES flops per bit, then one history flop prev.
  - rise = sync & ~prev; fall = ~sync & prev.
- IN reflects the pin even when DIR=1.
- STATUS[i] next value:
  - set if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]);
  - else cleared if a STATUS write has wdata[i]=1;
  - else held.
  - Set wins over a simultaneous clear.
- Enabling RISE_EN/FALL_EN does not retroactively set STATUS for past edges.
- irq = |STATUS; combinational from the STATUS flops, no extra stage.
- Read: on sel & ~we, rdata <= selected register at the next edge. rdata holds its value when there is no read. A read has no side effects.

## Timing
- Reset (rst_n=0 at an edge): all of the following are 0:
  - OUT, DIR, RISE_EN, FALL_EN, STATUS;
  - synchroniser and prev flops;
  - rdata, gpio_out, gpio_oe, irq.
- Register writes take effect at the access edge. gpio_out/gpio_oe change in the following cycle.
- Read latency: 1 cycle. A read in the cycle after a write returns the new value.
- Input path: edge 1 is the first rising edge that samples a new gpio_in level.
  - Sync output changes at edge SYNC_STAGES.
  - STATUS and irq assert after edge SYNC_STAGES+1.
  - An IN read issued after edge SYNC_STAGES returns the new level.
- Pulses shorter than one clock may be missed.
- One STATUS bit records any number of edges.
- Reset mid-operation clears all state in one edge. An in-flight read returns nothing; rdata is 0.
- Back-to-back accesses every cycle are supported; there is no wait state.

## Configuration
- GPIO_CTRL_SETCLR_EN defined:
  - Write to OUT_SET: OUT <= OUT | wdata.
  - Write to OUT_CLR: OUT <= OUT & ~wdata.
  - Both registers read as 0.
- GPIO_CTRL_SETCLR_EN undefined: addresses 6 and 7 ignore writes and read as 0.
- Reserved addresses always read 0.

## Test plan
- Reset with WIDTH=8: hold rst_n=0 for 2 cycles -> gpio_out=0, gpio_oe=0, irq=0, rdata=0. Read of every register returns 0.
- Write OUT=0xFFFF_FFA5 and DIR=0x0F with WIDTH=8 -> gpio_out=0xA5 and gpio_oe=0x0F next cycle. OUT read returns 0x0000_00A5.
- RISE_EN=0x01, SYNC_STAGES=2, gpio_in 0->1 on bit 0 -> STATUS=0x01 and irq=1 after edge 3. Write STATUS=0x01 -> irq=0 next cycle. Driving the pin low with FALL_EN=0 leaves STATUS=0.
- FALL_EN=0x02: issue a falling edge on bit 1 in the same cycle as a STATUS write of 0x02 -> STATUS[1] stays 1 (set wins).
- With GPIO_CTRL_SETCLR_EN, OUT=0x0F: write OUT_SET=0x30, then OUT_CLR=0x03 -> OUT=0x3C. Without the macro, OUT stays 0x0F.
- Write IN=0xFF while gpio_in=0x5A is stable -> IN read returns 0x5A. Assert reset between a read request and its return -> rdata=0.
